// File: rtl/fft_sdf_bfly_stage_if.sv
// rtl/fft_sdf_bfly_stage_if.sv - sample-in / butterfly-out lane bundle for the SDF stage
interface fft_sdf_bfly_stage_if #(
  parameter int LANES = 16,
  parameter int IN_W  = 9
);
  logic                       din_valid;
  logic                       din_ready;
  logic [LANES-1:0][IN_W-1:0] din_i;
  logic [LANES-1:0][IN_W-1:0] din_q;
  logic                       dout_valid;
  logic [LANES-1:0][IN_W:0]   dout_i;
  logic [LANES-1:0][IN_W:0]   dout_q;
  logic                       dout_sum;

  modport master (
    output din_valid, din_i, din_q,
    input  din_ready, dout_valid, dout_i, dout_q, dout_sum
  );

  modport slave (
    input  din_valid, din_i, din_q,
    output din_ready, dout_valid, dout_i, dout_q, dout_sum
  );
endinterface

// File: rtl/fft_sdf_bfly_stage.sv
// rtl/fft_sdf_bfly_stage.sv - radix-2 single-delay-feedback butterfly stage, LANES wide
// Optional BFLY_SCALE_EN halves every sum/difference with round-half-up.
module fft_sdf_bfly_stage #(
  parameter int LANES = 16,
  parameter int IN_W  = 9,
  parameter int HALF  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fft_sdf_bfly_stage_if.slave bus
);
  localparam int OW = IN_W + 1;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready;
  logic          accept;
  logic          last;
  logic          mem_we;
  logic          dout_load;
  logic          dout_sum_d;

  // Delay line: first half of the frame, later replaced by the differences.
  logic signed [OW-1:0] mem_i [HALF][LANES];
  logic signed [OW-1:0] mem_q [HALF][LANES];

  logic signed [OW-1:0] rd_i   [LANES];
  logic signed [OW-1:0] rd_q   [LANES];
  logic signed [OW:0]   a_i    [LANES];
  logic signed [OW:0]   a_q    [LANES];
  logic signed [OW:0]   b_i    [LANES];
  logic signed [OW:0]   b_q    [LANES];
  logic signed [OW-1:0] sum_i  [LANES];
  logic signed [OW-1:0] sum_q  [LANES];
  logic signed [OW-1:0] diff_i [LANES];
  logic signed [OW-1:0] diff_q [LANES];
  logic signed [OW-1:0] wr_i   [LANES];
  logic signed [OW-1:0] wr_q   [LANES];
  logic signed [OW-1:0] nx_i   [LANES];
  logic signed [OW-1:0] nx_q   [LANES];

  logic                     dout_valid_q;
  logic                     dout_sum_q;
  logic [LANES-1:0][OW-1:0] dout_i_q;
  logic [LANES-1:0][OW-1:0] dout_q_q;

  // Operands arrive one bit wider than the result so the rounding add cannot wrap.
  function automatic logic signed [OW-1:0] post(input logic signed [OW:0] x);
`ifdef BFLY_SCALE_EN
    logic signed [OW:0] t;
    t = x + (OW+1)'(1);
    return OW'(t >>> 1);
`else
    return OW'(x);
`endif
  endfunction

  assign ready  = (state_q != DRAIN);
  assign accept = bus.din_valid && ready;
  assign last   = (cnt_q == LAST);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_i[l]   = mem_i[cnt_q][l];
      rd_q[l]   = mem_q[cnt_q][l];
      a_i[l]    = (OW+1)'(rd_i[l]);
      a_q[l]    = (OW+1)'(rd_q[l]);
      b_i[l]    = (OW+1)'($signed(bus.din_i[l]));
      b_q[l]    = (OW+1)'($signed(bus.din_q[l]));
      sum_i[l]  = post(a_i[l] + b_i[l]);
      sum_q[l]  = post(a_q[l] + b_q[l]);
      diff_i[l] = post(a_i[l] - b_i[l]);
      diff_q[l] = post(a_q[l] - b_q[l]);
      wr_i[l]   = (state_q == FILL) ? OW'(b_i[l]) : diff_i[l];
      wr_q[l]   = (state_q == FILL) ? OW'(b_q[l]) : diff_q[l];
      nx_i[l]   = (state_q == DRAIN) ? rd_i[l] : sum_i[l];
      nx_q[l]   = (state_q == DRAIN) ? rd_q[l] : sum_q[l];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    dout_load  = 1'b0;
    dout_sum_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          mem_we = 1'b1;
          cnt_d  = last ? '0 : cnt_q + CW'(1);
          if (last) state_d = BFLY;
        end
      end
      BFLY: begin
        if (accept) begin
          mem_we     = 1'b1;
          dout_load  = 1'b1;
          dout_sum_d = 1'b1;
          cnt_d      = last ? '0 : cnt_q + CW'(1);
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        dout_load = 1'b1;
        cnt_d     = last ? '0 : cnt_q + CW'(1);
        if (last) state_d = FILL;
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_sum_q   <= 1'b0;
      dout_i_q     <= '0;
      dout_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_load;
      if (dout_load) begin
        dout_sum_q <= dout_sum_d;
        for (int l = 0; l < LANES; l++) begin
          dout_i_q[l] <= nx_i[l];
          dout_q_q[l] <= nx_q[l];
        end
      end
    end
  end

  // Slot is read combinationally above, so this write sees the old value in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < LANES; l++) begin
        mem_i[cnt_q][l] <= wr_i[l];
        mem_q[cnt_q][l] <= wr_q[l];
      end
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sum   = dout_sum_q;
  assign bus.dout_i     = dout_i_q;
  assign bus.dout_q     = dout_q_q;
endmodule

// File: tb/tb_fft_sdf_bfly_stage.sv
// tb/tb_fft_sdf_bfly_stage.sv - vector table, reset/gap corners and random frames vs a frame-level model
module tb_fft_sdf_bfly_stage;
  localparam int L  = 16;
  localparam int W  = 9;
  localparam int H  = 16;
  localparam int OW = W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_sdf_bfly_stage_if #(.LANES(L), .IN_W(W)) bus ();

  fft_sdf_bfly_stage #(.LANES(L), .IN_W(W), .HALF(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scl(input int x);
`ifdef BFLY_SCALE_EN
    return (x + 1) >>> 1;
`else
    return x;
`endif
  endfunction

  task automatic chk_lanes(input string name, input logic [L-1:0][OW-1:0] v, input int exp);
    int bad = 0;
    for (int l = 0; l < L; l++) if ($signed(v[l]) != exp) bad = l;
    chk(name, $signed(v[bad]), exp);
  endtask

  typedef struct {
    logic [L-1:0][OW-1:0] i;
    logic [L-1:0][OW-1:0] q;
    bit                   s;
  } cap_t;
  cap_t cap[$];

  // Frame-level reference: sum k = x[k]+x[k+H] on beats H..2H-1, then diff k = x[k]-x[k+H].
  int frm_i [2*H][L];
  int frm_q [2*H][L];
  int pend_i [L];
  int pend_q [L];
  int beats, drain_k, mbad;
  bit draining, pend_v, pend_sum;
  logic [L-1:0][OW-1:0] last_i, last_q;
  cap_t c;

  always @(negedge clk) begin
    if (rst) begin
      beats = 0; drain_k = 0; draining = 0; pend_v = 0;
      last_i = '0; last_q = '0;
    end else begin
      chk("dout_valid", int'(bus.dout_valid), int'(pend_v));
      chk("din_ready", int'(bus.din_ready), int'(!draining));
      if (pend_v) begin
        mbad = 0;
        for (int l = 0; l < L; l++) if ($signed(bus.dout_i[l]) != pend_i[l]) mbad = l;
        chk("model dout_i", $signed(bus.dout_i[mbad]), pend_i[mbad]);
        mbad = 0;
        for (int l = 0; l < L; l++) if ($signed(bus.dout_q[l]) != pend_q[l]) mbad = l;
        chk("model dout_q", $signed(bus.dout_q[mbad]), pend_q[mbad]);
        chk("model dout_sum", int'(bus.dout_sum), int'(pend_sum));
      end else begin
        chk("hold dout_i", int'(bus.dout_i == last_i), 1);
        chk("hold dout_q", int'(bus.dout_q == last_q), 1);
      end
      if (bus.dout_valid) begin
        c.i = bus.dout_i; c.q = bus.dout_q; c.s = bus.dout_sum;
        cap.push_back(c);
      end
      last_i = bus.dout_i;
      last_q = bus.dout_q;
      pend_v = 0;
      if (draining) begin
        for (int l = 0; l < L; l++) begin
          pend_i[l] = scl(frm_i[drain_k][l] - frm_i[drain_k+H][l]);
          pend_q[l] = scl(frm_q[drain_k][l] - frm_q[drain_k+H][l]);
        end
        pend_v = 1; pend_sum = 0;
        drain_k++;
        if (drain_k == H) draining = 0;
      end else if (bus.din_valid) begin
        for (int l = 0; l < L; l++) begin
          frm_i[beats][l] = $signed(bus.din_i[l]);
          frm_q[beats][l] = $signed(bus.din_q[l]);
        end
        if (beats >= H) begin
          for (int l = 0; l < L; l++) begin
            pend_i[l] = scl(frm_i[beats-H][l] + frm_i[beats][l]);
            pend_q[l] = scl(frm_q[beats-H][l] + frm_q[beats][l]);
          end
          pend_v = 1; pend_sum = 1;
        end
        beats++;
        if (beats == 2*H) begin beats = 0; draining = 1; drain_k = 0; end
      end
    end
  end

  logic [L-1:0][W-1:0] fr_i [2*H];
  logic [L-1:0][W-1:0] fr_q [2*H];

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random idles
  task automatic drive(input int gap_mode, input int max_beats);
    int idx = 0;
    int cyc = 0;
    bit tog = 0;
    bit v;
    while (idx < max_beats && cyc < 4000) begin
      case (gap_mode)
        1:       begin v = !tog; tog = !tog; end
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      bus.din_valid = v;
      bus.din_i = v ? fr_i[idx] : {L{W'($urandom)}};
      bus.din_q = v ? fr_q[idx] : {L{W'($urandom)}};
      if (v && bus.din_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.din_valid = 1'b0;
    if (idx < max_beats) chk("drive timeout", idx, max_beats);
  endtask

  task automatic run_frame(input int gap_mode);
    cap.delete();
    drive(gap_mode, 2*H);
    repeat (H + 3) @(posedge clk);
    #1;
    chk("frame output count", cap.size(), 2*H);
  endtask

  task automatic fill_const(input int a, input int b);
    for (int k = 0; k < 2*H; k++) begin
      fr_i[k] = {L{W'((k < H) ? a : b)}};
      fr_q[k] = '0;
    end
  endtask

  typedef struct { int a; int b; int es; int ed; } vec_t;
  vec_t tbl[6];

  initial begin
`ifdef BFLY_SCALE_EN
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{-256, -256, -256, 0};
    tbl[2] = '{255, -256, 0, 256};
    tbl[3] = '{255, 255, 255, 0};
    tbl[4] = '{3, -2, 1, 3};
    tbl[5] = '{-3, 0, -1, -1};
`else
    tbl[0] = '{1, 1, 2, 0};
    tbl[1] = '{-256, -256, -512, 0};
    tbl[2] = '{255, -256, -1, 511};
    tbl[3] = '{255, 255, 510, 0};
    tbl[4] = '{3, -2, 1, 5};
    tbl[5] = '{-3, 0, -3, -3};
`endif

    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_i = '0;
    bus.din_q = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout_valid", int'(bus.dout_valid), 0);
    chk("reset dout_sum", int'(bus.dout_sum), 0);
    chk("reset dout_i zero", int'(bus.dout_i == '0), 1);
    chk("reset din_ready", int'(bus.din_ready), 1);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      fill_const(tbl[t].a, tbl[t].b);
      run_frame(0);
      if (cap.size() >= 2*H) begin
        chk_lanes("table sum first", cap[0].i, tbl[t].es);
        chk_lanes("table sum last", cap[H-1].i, tbl[t].es);
        chk("table sum flag", int'(cap[0].s), 1);
        chk_lanes("table diff first", cap[H].i, tbl[t].ed);
        chk_lanes("table diff last", cap[2*H-1].i, tbl[t].ed);
        chk("table diff flag", int'(cap[H].s), 0);
        chk_lanes("table q sum", cap[0].q, scl(0));
      end
    end

    fill_const(1, 1);
    run_frame(1);
    if (cap.size() >= 2*H) begin
      chk_lanes("gapped sum", cap[0].i, tbl[0].es);
      chk_lanes("gapped diff", cap[2*H-1].i, tbl[0].ed);
    end

    for (int k = 0; k < 2*H; k++) begin
      fr_i[k] = {L{W'(k)}};
      fr_q[k] = {L{W'(-k)}};
    end
    cap.delete();
    drive(0, 20);
    rst = 1'b1;
    #1;
    chk("midrun rst dout_valid", int'(bus.dout_valid), 0);
    chk("midrun rst dout_i zero", int'(bus.dout_i == '0), 1);
    chk("midrun rst dout_q zero", int'(bus.dout_q == '0), 1);
    chk("midrun rst dout_sum", int'(bus.dout_sum), 0);
    chk("midrun rst din_ready", int'(bus.din_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(0);
    if (cap.size() >= 2*H) begin
      chk_lanes("ramp sum k0", cap[0].i, scl(16));
      chk_lanes("ramp sum k7", cap[7].i, scl(2*7 + 16));
      chk_lanes("ramp sum k15", cap[H-1].i, scl(2*15 + 16));
      chk_lanes("ramp q sum k5", cap[5].q, scl(-(2*5 + 16)));
      chk_lanes("ramp diff k0", cap[H].i, scl(-16));
      chk_lanes("ramp diff k15", cap[2*H-1].i, scl(-16));
      chk_lanes("ramp q diff", cap[H+3].q, scl(16));
    end

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 2*H; k++) begin
        for (int l = 0; l < L; l++) begin
          fr_i[k][l] = W'($urandom_range(0, (1 << W) - 1));
          fr_q[k][l] = W'($urandom_range(0, (1 << W) - 1));
        end
      end
      run_frame(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
